// File: rtl/rg_pkg.sv
// rg_pkg: constants and state types shared by the ring-generator
// post-processing stage (packer, health test and von Neumann debiaser).
package rg_pkg;

    // Default packed word width and repetition-count cutoff.
    localparam int unsigned WORD_W_DEF     = 32;
    localparam int unsigned RCT_CUTOFF_DEF = 32;

    // Packer state: FILL collects bits, FULL holds a finished word while
    // the previous word is still waiting for an acknowledge.
    typedef enum logic {
        PK_FILL = 1'b0,
        PK_FULL = 1'b1
    } pack_state_t;

    // Debiaser state: EMPTY waits for the first bit of a pair, HALF has it.
    typedef enum logic {
        DB_EMPTY = 1'b0,
        DB_HALF  = 1'b1
    } debias_state_t;

endpackage : rg_pkg

// File: rtl/rg_vn_debias.sv
// rg_vn_debias: von Neumann debiaser for the raw ring-generator stream.
// Raw bits are taken in non-overlapping pairs; 01 yields 0, 10 yields 1,
// 00 and 11 yield nothing. The output is presented in the same cycle as
// the second bit of the pair. flush drops a half-collected pair.
// Only built when TRNG_VN_DEBIAS_EN is defined.
`ifdef TRNG_VN_DEBIAS_EN
module rg_vn_debias
    import rg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    input  logic flush,
    output logic dbit,
    output logic dvalid
);

    debias_state_t state;
    logic          first_bit;

    // Pair collector: remember the first sample of a pair, return to EMPTY on the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DB_EMPTY;
            first_bit <= 1'b0;
        end else if (flush) begin
            state <= DB_EMPTY;
        end else if (en) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            unique case (state)
                DB_EMPTY: begin
                    first_bit <= raw;
                    state     <= DB_HALF;
                end
                DB_HALF: begin
                    state <= DB_EMPTY;
                end
                default: begin
                    state <= DB_EMPTY;
                end
            endcase
        end
    end

    // Emit the first bit of an unequal pair when its second bit arrives.
    always_comb begin
        // NOTE: every output gets a default before any condition, so no
        // path leaves it unassigned and no latch is inferred.
        dbit   = first_bit;
        dvalid = 1'b0;
        if (en && !flush && (state == DB_HALF) && (raw != first_bit)) begin
            dvalid = 1'b1;
        end
    end

endmodule : rg_vn_debias
`endif

// File: rtl/rg_post_packer.sv
// rg_post_packer: samples the ring-generator serial bit, optionally
// debiases it, packs accepted bits LSB-first into WORD_W-bit words and
// hands them out through a valid/acknowledge handshake. A repetition-count
// health test on the raw stream drives a sticky failure flag.
// Optional feature macro: TRNG_VN_DEBIAS_EN (von Neumann debiaser).
module rg_post_packer
    import rg_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iEn,
    input  logic              iSerial,
    input  logic              iRdAck,
    output logic [WORD_W-1:0] oData,
    output logic              oValid,
    output logic              oRctFail
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [RCT_W-1:0] RCT_MAX  = RCT_W'(RCT_CUTOFF);
    localparam logic [RCT_W-1:0] RCT_ONE  = RCT_W'(1);

    // ------------------------------------------------------------------
    // Accepted-bit source
    // ------------------------------------------------------------------
    logic        acc_bit;
    logic        acc_valid;
    pack_state_t state;

`ifdef TRNG_VN_DEBIAS_EN
    logic flush;

    // A held word blocks the packer, so pairs straddling that time are dropped.
    assign flush = (state == PK_FULL);

    rg_vn_debias u_debias (
        .clk    (iClk),
        .rst_n  (iRstn),
        .en     (iEn),
        .raw    (iSerial),
        .flush  (flush),
        .dbit   (acc_bit),
        .dvalid (acc_valid)
    );
`else
    // Without debiasing every enabled raw sample is an accepted bit.
    assign acc_bit   = iSerial;
    assign acc_valid = iEn;
`endif

    // ------------------------------------------------------------------
    // Packer and handshake
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              take;
    logic              word_done;
    logic              ack_eff;

    // New bits enter at the MSB so the first bit of a word lands at bit 0.
    assign acc_next  = {acc_bit, acc[WORD_W-1:1]};
    assign take      = acc_valid && (state == PK_FILL);
    assign word_done = take && (bit_cnt == CNT_LAST);
    assign ack_eff   = iRdAck && oValid;

    // Shift accepted bits, publish finished words, and track FILL/FULL.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            // NOTE: the accumulator and output word are datapath registers but
            // are reset anyway, so a reset mid-word leaves nothing to leak out.
            acc      <= '0;
            bit_cnt  <= '0;
            state    <= PK_FILL;
            oData    <= '0;
            oValid   <= 1'b0;
        end else begin
            if (take) begin
                acc     <= acc_next;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end

            if (word_done) begin
                if (!oValid || iRdAck) begin
                    // Output slot free or being freed this edge: publish directly.
                    oData  <= acc_next;
                    oValid <= 1'b1;
                end else begin
                    // Previous word unread: keep this one in the accumulator.
                    state <= PK_FULL;
                end
            end else if (ack_eff) begin
                if (state == PK_FULL) begin
                    oData <= acc;
                    state <= PK_FILL;
                end else begin
                    oValid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Repetition-count health test on the raw stream
    // ------------------------------------------------------------------
    logic [RCT_W-1:0] rct_cnt;
    logic [RCT_W-1:0] rct_next;
    logic             last_bit;

    // Next run length: restart at one on a change or first sample, saturate at cutoff.
    always_comb begin
        rct_next = RCT_ONE;
        if ((rct_cnt != '0) && (iSerial == last_bit)) begin
            rct_next = (rct_cnt == RCT_MAX) ? rct_cnt : rct_cnt + 1'b1;
        end
    end

    // Track the run length and latch the failure flag until reset.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            rct_cnt  <= '0;
            last_bit <= 1'b0;
            oRctFail <= 1'b0;
        end else if (iEn) begin
            rct_cnt  <= rct_next;
            last_bit <= iSerial;
            if (rct_next == RCT_MAX) begin
                oRctFail <= 1'b1;
            end
        end
    end

endmodule : rg_post_packer

// File: tb/tb_rg_post_packer.sv
// tb_rg_post_packer: directed and randomized checks of rg_post_packer
// against a word-level behavioural model. Works with or without
// TRNG_VN_DEBIAS_EN defined.
module tb_rg_post_packer;

    localparam int WORD_W     = 32;
    localparam int RCT_CUTOFF = 32;

`ifdef TRNG_VN_DEBIAS_EN
    localparam int          N_FIRST   = 2 * WORD_W;
    localparam logic [31:0] EXP_FIRST = 32'hFFFF_FFFF;
`else
    localparam int          N_FIRST   = WORD_W;
    localparam logic [31:0] EXP_FIRST = 32'h5555_5555;
`endif

    logic              iClk    = 1'b0;
    logic              iRstn   = 1'b0;
    logic              iEn     = 1'b0;
    logic              iSerial = 1'b0;
    logic              iRdAck  = 1'b0;
    logic [WORD_W-1:0] oData;
    logic              oValid;
    logic              oRctFail;

    int n_tests = 0;
    int n_fail  = 0;

    rg_post_packer #(
        .WORD_W     (WORD_W),
        .RCT_CUTOFF (RCT_CUTOFF)
    ) dut (
        .iClk     (iClk),
        .iRstn    (iRstn),
        .iEn      (iEn),
        .iSerial  (iSerial),
        .iRdAck   (iRdAck),
        .oData    (oData),
        .oValid   (oValid),
        .oRctFail (oRctFail)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: bits are placed by position in a word, finished
    // words go to the output slot or a single holding slot.
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] m_data  = '0;
    logic [WORD_W-1:0] m_word  = '0;
    logic [WORD_W-1:0] m_held  = '0;
    logic              m_valid = 1'b0;
    logic              m_full  = 1'b0;
    logic              m_fail  = 1'b0;
    logic              m_seen  = 1'b0;
    logic              m_last  = 1'b0;
    logic              m_half_have = 1'b0;
    logic              m_half_bit  = 1'b0;
    int                m_n   = 0;
    int                m_run = 0;

    task automatic model_reset();
        m_data = '0; m_word = '0; m_held = '0;
        m_valid = 1'b0; m_full = 1'b0; m_fail = 1'b0;
        m_seen = 1'b0; m_last = 1'b0;
        m_half_have = 1'b0; m_half_bit = 1'b0;
        m_n = 0; m_run = 0;
    endtask

    task automatic model_edge(input logic en, input logic ser, input logic ack);
        logic ack_eff, full_before, have, b, done;
        ack_eff     = ack && m_valid;
        full_before = m_full;
        have        = 1'b0;
        b           = 1'b0;
        done        = 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
        if (full_before) m_half_have = 1'b0;
`endif
        if (en) begin
            m_run  = (m_seen && ser == m_last) ? m_run + 1 : 1;
            m_seen = 1'b1;
            m_last = ser;
            if (m_run >= RCT_CUTOFF) m_fail = 1'b1;
`ifdef TRNG_VN_DEBIAS_EN
            if (!full_before) begin
                if (!m_half_have) begin
                    m_half_have = 1'b1;
                    m_half_bit  = ser;
                end else begin
                    m_half_have = 1'b0;
                    if (ser != m_half_bit) begin
                        have = 1'b1;
                        b    = m_half_bit;
                    end
                end
            end
`else
            have = 1'b1;
            b    = ser;
`endif
        end
        if (have && !full_before) begin
            m_word[m_n] = b;
            m_n++;
            if (m_n == WORD_W) begin
                m_n  = 0;
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || ack) begin
                m_data  = m_word;
                m_valid = 1'b1;
            end else begin
                m_held = m_word;
                m_full = 1'b1;
            end
        end else if (ack_eff) begin
            if (m_full) begin
                m_data = m_held;
                m_full = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Model follows the DUT clock and its asynchronous reset.
    initial forever begin
        @(posedge iClk or negedge iRstn);
        if (!iRstn) model_reset();
        else        model_edge(iEn, iSerial, iRdAck);
    end

    // Compare process: outputs checked on every falling edge.
    initial forever begin
        @(negedge iClk);
        check("cyc_data",  oData,    m_data);
        check("cyc_valid", oValid,   m_valid);
        check("cyc_rct",   oRctFail, m_fail);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic en, input logic ser, input logic ack);
        iEn = en; iSerial = ser; iRdAck = ack;
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRstn = 1'b0; iEn = 1'b0; iSerial = 1'b0; iRdAck = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        iRstn = 1'b1;
    endtask

    // Feed bits v[lo..hi] as accepted bits; ack on the last raw sample if asked.
    task automatic send_range(input logic [WORD_W-1:0] v, input int lo, input int hi,
                              input logic ack_last);
        for (int i = lo; i <= hi; i++) begin
            logic a;
            a = ack_last && (i == hi);
`ifdef TRNG_VN_DEBIAS_EN
            step(1'b1, v[i], 1'b0);
            step(1'b1, ~v[i], a);
`else
            step(1'b1, v[i], a);
`endif
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic run_bit;
        logic ser;
        int   ack_pct;
        run_bit = 1'b0;

        do_reset();
        check("reset_data",  oData,    32'h0);
        check("reset_valid", oValid,   1'b0);
        check("reset_rct",   oRctFail, 1'b0);

        // Alternating 1,0 from reset, no acknowledge.
        for (int i = 0; i < N_FIRST - 1; i++) step(1'b1, (i % 2) == 0, 1'b0);
        check("alt_not_yet", oValid, 1'b0);
        step(1'b1, ((N_FIRST - 1) % 2) == 0, 1'b0);
        check("alt_valid", oValid, 1'b1);
        check("alt_data",  oData,  EXP_FIRST);
        check("alt_model", m_data, EXP_FIRST);

`ifdef TRNG_VN_DEBIAS_EN
        // Pairs (0,1) give zeros; pairs (1,1) give nothing.
        do_reset();
        for (int i = 0; i < WORD_W; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        check("vn01_valid", oValid, 1'b1);
        check("vn01_data",  oData,  32'h0);
        do_reset();
        for (int i = 0; i < 2 * WORD_W; i++) step(1'b1, 1'b1, 1'b0);
        check("vn11_valid", oValid, 1'b0);
`endif

        // Constant ones: health test trips on the cutoff-th sample.
        do_reset();
        for (int i = 0; i < RCT_CUTOFF - 1; i++) step(1'b1, 1'b1, 1'b0);
        check("rct_before", oRctFail, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("rct_trip",  oRctFail, 1'b1);
        check("rct_model", m_fail,   1'b1);
`ifndef TRNG_VN_DEBIAS_EN
        check("rct_word_valid", oValid, 1'b1);
        check("rct_word_data",  oData,  32'hFFFF_FFFF);
`endif
        do_reset();
        check("rct_cleared", oRctFail, 1'b0);

        // Two words without acknowledge: second is held internally.
        send_range(32'h1234_5678, 0, WORD_W - 1, 1'b0);
        check("w1_valid", oValid, 1'b1);
        check("w1_data",  oData,  32'h1234_5678);
        send_range(32'hCAFE_F00D, 0, WORD_W - 1, 1'b0);
        check("held_valid", oValid, 1'b1);
        check("held_data",  oData,  32'h1234_5678);
        step(1'b0, 1'b0, 1'b1);
        check("ack1_valid", oValid, 1'b1);
        check("ack1_data",  oData,  32'hCAFE_F00D);
        step(1'b0, 1'b0, 1'b1);
        check("ack2_valid", oValid, 1'b0);

        // Acknowledge on the completing edge of the next word: no gap.
        send_range(32'hA5A5_0F0F, 0, WORD_W - 1, 1'b0);
        check("w3_data", oData, 32'hA5A5_0F0F);
        send_range(32'h0BAD_BEEF, 0, WORD_W - 2, 1'b0);
        check("w4_pre_valid", oValid, 1'b1);
        check("w4_pre_data",  oData,  32'hA5A5_0F0F);
        send_range(32'h0BAD_BEEF, WORD_W - 1, WORD_W - 1, 1'b1);
        check("w4_valid", oValid, 1'b1);
        check("w4_data",  oData,  32'h0BAD_BEEF);

        // Reset asserted mid-word, away from the clock edge.
        send_range(32'h1357_9BDF, 0, 16, 1'b0);
        #3;
        iRstn = 1'b0;
        #1;
        check("async_data",  oData,    32'h0);
        check("async_valid", oValid,   1'b0);
        check("async_rct",   oRctFail, 1'b0);
        @(posedge iClk);
        #1;
        iRstn = 1'b1;
        send_range(32'h2468_ACE1, 0, WORD_W - 2, 1'b0);
        check("after_rst_partial", oValid, 1'b0);
        send_range(32'h2468_ACE1, WORD_W - 1, WORD_W - 1, 1'b0);
        check("after_rst_valid", oValid, 1'b1);
        check("after_rst_data",  oData,  32'h2468_ACE1);

        // Randomized traffic with varying acknowledge rates and long runs.
        for (int c = 0; c < 3000; c++) begin
            ack_pct = (c < 1000) ? 2 : ((c < 2000) ? 40 : 12);
            if ((c % 500) == 0) run_bit = 1'($urandom_range(0, 1));
            if ((c % 500) < 40) ser = run_bit;
            else                ser = 1'($urandom_range(0, 1));
            if (c == 1500) begin
                #3;
                iRstn = 1'b0;
                #4;
                iRstn = 1'b1;
            end
            step($urandom_range(0, 9) < 8, ser, $urandom_range(0, 99) < ack_pct);
        end
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rg_post_packer
